// File: rtl/ram_1r1w_debug.sv
// ram_1r1w_debug: one-read/one-write word memory for kernel datapaths with a
// combinational debug read port and a debug write port. Contents are not
// reset; reset clears only the read pipeline and the sticky out-of-range flag.
module ram_1r1w_debug #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      raddr_0,
    output logic [WIDTH-1:0] rdata_0,
    input  logic [31:0]      waddr_0,
    input  logic             wen_0,
    input  logic [WIDTH-1:0] wdata_0,
    input  logic [31:0]      debug_addr,
    output logic [WIDTH-1:0] debug_data,
    input  logic [31:0]      debug_write_addr,
    input  logic             debug_write_en,
    input  logic [WIDTH-1:0] debug_write_data,
    output logic             oob_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             rd_ok;
    logic [WIDTH-1:0] rd_word;
    logic             dbg_rd_ok;
    logic             wr0_fire;
    logic             dbgw_fire;
    logic [AW-1:0]    wr0_idx;
    logic [AW-1:0]    dbgw_idx;
    logic             oob_hit;
    logic             oob_err_d;
    logic             oob_err_q;

    // Full 32-bit compare so upper address bits never alias into the array.
    function automatic logic addr_ok(input logic [31:0] a);
        return a < 32'(DEPTH);
    endfunction

    // Address decode, read muxes, write qualification and error detection.
    always_comb begin
        rd_ok      = addr_ok(raddr_0);
        rd_word    = rd_ok ? mem_q[raddr_0[AW-1:0]] : '0;

        dbg_rd_ok  = addr_ok(debug_addr);
        debug_data = dbg_rd_ok ? mem_q[debug_addr[AW-1:0]] : '0;

        wr0_fire   = wen_0 && addr_ok(waddr_0);
        dbgw_fire  = debug_write_en && addr_ok(debug_write_addr);
        wr0_idx    = waddr_0[AW-1:0];
        dbgw_idx   = debug_write_addr[AW-1:0];

        // Debug reads are excluded: inspecting memory must not disturb the flag.
        oob_hit    = !rd_ok
                   || (wen_0 && !addr_ok(waddr_0))
                   || (debug_write_en && !addr_ok(debug_write_addr));
        oob_err_d  = oob_err_q || oob_hit;
    end

    // Memory array: no reset, writes honoured even while rst is high.
    // The debug write is issued last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (wr0_fire) begin
            mem_q[wr0_idx] <= wdata_0;
        end
        if (dbgw_fire) begin
            mem_q[dbgw_idx] <= debug_write_data;
        end
    end

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            oob_err_q <= 1'b0;
        end else begin
            oob_err_q <= oob_err_d;
        end
    end

    assign oob_err = oob_err_q;

    generate
        if (READ_LATENCY == 0) begin : g_comb_read
            assign rdata_0 = rd_word;
        end else begin : g_pipe_read
            logic [WIDTH-1:0] stage_d [READ_LATENCY];
            logic [WIDTH-1:0] stage_q [READ_LATENCY];

            // Next-state of the read shift register: stage 0 takes the array word.
            always_comb begin
                stage_d[0] = rd_word;
                for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            // Read pipeline registers; reset flushes every pending read to zero.
            always_ff @(posedge clk) begin
                for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                    if (rst) begin
                        stage_q[i] <= '0;
                    end else begin
                        stage_q[i] <= stage_d[i];
                    end
                end
            end

            assign rdata_0 = stage_q[READ_LATENCY-1];
        end
    endgenerate

endmodule

// File: tb/tb_ram_1r1w_debug.sv
// Directed bench for ram_1r1w_debug: table of single-cycle vectors against a
// latency-1 instance, plus hand sequences for latency-3 pipelining and flush.
module tb_ram_1r1w_debug;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] raddr_0, waddr_0, wdata_0;
    logic        wen_0;
    logic [31:0] debug_addr, debug_write_addr, debug_write_data;
    logic        debug_write_en;

    logic [31:0] rdata_l1, dbg_l1;
    logic        oob_l1;
    logic [31:0] rdata_l3, dbg_l3;
    logic        oob_l3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_1r1w_debug #(.WIDTH(32), .DEPTH(64), .READ_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .raddr_0(raddr_0), .rdata_0(rdata_l1),
        .waddr_0(waddr_0), .wen_0(wen_0), .wdata_0(wdata_0),
        .debug_addr(debug_addr), .debug_data(dbg_l1),
        .debug_write_addr(debug_write_addr), .debug_write_en(debug_write_en),
        .debug_write_data(debug_write_data),
        .oob_err(oob_l1)
    );

    ram_1r1w_debug #(.WIDTH(32), .DEPTH(64), .READ_LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .raddr_0(raddr_0), .rdata_0(rdata_l3),
        .waddr_0(waddr_0), .wen_0(wen_0), .wdata_0(wdata_0),
        .debug_addr(debug_addr), .debug_data(dbg_l3),
        .debug_write_addr(debug_write_addr), .debug_write_en(debug_write_en),
        .debug_write_data(debug_write_data),
        .oob_err(oob_l3)
    );

    typedef struct {
        logic        rst;
        logic [31:0] raddr;
        logic        wen;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        dwen;
        logic [31:0] dwaddr;
        logic [31:0] dwdata;
        logic [31:0] daddr;
        logic [31:0] e_rdata;
        logic [31:0] e_dbg;
        logic        e_oob;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    function automatic vec_t mk(
        input logic r, input logic [31:0] ra,
        input logic we, input logic [31:0] wa, input logic [31:0] wd,
        input logic de, input logic [31:0] dwa, input logic [31:0] dwd,
        input logic [31:0] da,
        input logic [31:0] er, input logic [31:0] ed, input logic eo);
        vec_t v;
        v.rst = r; v.raddr = ra; v.wen = we; v.waddr = wa; v.wdata = wd;
        v.dwen = de; v.dwaddr = dwa; v.dwdata = dwd; v.daddr = da;
        v.e_rdata = er; v.e_dbg = ed; v.e_oob = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; raddr_0 = 32'd10; wen_0 = 1'b0; waddr_0 = '0; wdata_0 = '0;
        debug_write_en = 1'b0; debug_write_addr = '0; debug_write_data = '0;
        debug_addr = 32'd10;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst raddr wen waddr wdata dwen dwaddr dwdata daddr | rdata dbg oob
        vt[0]  = mk(1, 0,   1, 12, 0,  1, 10, 15, 10,   0, 15, 0); // writes during reset land
        vt[1]  = mk(1, 0,   1, 0,  0,  0, 0,  0,  12,   0, 0,  0); // reset holds, contents kept
        vt[2]  = mk(0, 10,  0, 0,  0,  0, 0,  0,  10,  15, 15, 0); // first read after reset
        vt[3]  = mk(0, 12,  1, 12, 15, 0, 0,  0,  12,   0, 15, 0); // read-before-write
        vt[4]  = mk(0, 12,  0, 0,  0,  0, 0,  0,  12,  15, 15, 0); // new data next cycle
        vt[5]  = mk(0, 10,  1, 5,  7,  1, 5,  9,  5,   15, 9,  0); // collision, debug wins
        vt[6]  = mk(0, 5,   0, 0,  0,  0, 0,  0,  5,    9, 9,  0);
        vt[7]  = mk(0, 10,  0, 0,  0,  0, 0,  0,  64,  15, 0,  0); // oob debug read: 0, no flag
        vt[8]  = mk(0, 0,   1, 64, 3,  0, 0,  0,  0,    0, 0,  1); // oob write dropped, flag set
        vt[9]  = mk(0, 0,   0, 0,  0,  0, 0,  0,  0,    0, 0,  1); // no wrap into word 0, sticky
        vt[10] = mk(0, 10,  0, 0,  0,  0, 0,  0,  10,  15, 15, 1);
        vt[11] = mk(1, 10,  0, 0,  0,  0, 0,  0,  10,   0, 15, 0); // reset clears flag
        vt[12] = mk(0, 10,  0, 0,  0,  0, 0,  0,  10,  15, 15, 0);
        vt[13] = mk(0, 100, 0, 0,  0,  0, 0,  0,  10,   0, 15, 1); // oob port-0 read
        vt[14] = mk(1, 10,  0, 0,  0,  0, 0,  0,  10,   0, 15, 0);
        vt[15] = mk(0, 10,  0, 0,  0,  1, 70, 1,  10,  15, 15, 1); // oob debug write sets flag
        vt[16] = mk(1, 10,  0, 0,  0,  0, 0,  0,  10,   0, 15, 0);
        vt[17] = mk(0, 0,   0, 200, 5, 0, 0,  0,  0,    0, 0,  0); // disabled oob write ignored

        idle_inputs();
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = vt[i].rst; raddr_0 = vt[i].raddr;
            wen_0 = vt[i].wen; waddr_0 = vt[i].waddr; wdata_0 = vt[i].wdata;
            debug_write_en = vt[i].dwen; debug_write_addr = vt[i].dwaddr;
            debug_write_data = vt[i].dwdata; debug_addr = vt[i].daddr;
            @(posedge clk); #1;
            chk($sformatf("v%0d rdata_0", i), rdata_l1, vt[i].e_rdata);
            chk($sformatf("v%0d debug_data", i), dbg_l1, vt[i].e_dbg);
            chk($sformatf("v%0d oob_err", i), {31'd0, oob_l1}, {31'd0, vt[i].e_oob});
        end

        // Preload words 1..3 while holding raddr_0 at 10 to fill the latency-3 pipe.
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            idle_inputs();
            debug_write_en = 1'b1; debug_write_addr = 32'(i); debug_write_data = 32'(11 * i);
            @(posedge clk);
        end
        @(negedge clk); idle_inputs(); @(posedge clk); #1;
        chk("l3 steady", rdata_l3, 32'd15);
        chk("l3 oob clear", {31'd0, oob_l3}, 32'd0);

        // Back-to-back reads of 1,2,3: results appear on edges 3,4,5.
        begin
            logic [31:0] exp_l3 [6];
            logic [31:0] ra [6];
            ra = '{32'd1, 32'd2, 32'd3, 32'd10, 32'd10, 32'd10};
            exp_l3 = '{32'd15, 32'd15, 32'd11, 32'd22, 32'd33, 32'd15};
            for (int e = 0; e < 6; e++) begin
                @(negedge clk); raddr_0 = ra[e];
                @(posedge clk); #1;
                chk($sformatf("l3 edge%0d", e + 1), rdata_l3, exp_l3[e]);
            end
        end

        // Reset arriving on the third read edge flushes everything in flight.
        begin
            logic [31:0] ra [6];
            logic        rr [6];
            logic [31:0] exp_l3 [6];
            ra = '{32'd1, 32'd2, 32'd3, 32'd10, 32'd10, 32'd10};
            rr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            exp_l3 = '{32'd15, 32'd15, 32'd0, 32'd0, 32'd0, 32'd15};
            for (int e = 0; e < 6; e++) begin
                @(negedge clk); raddr_0 = ra[e]; rst = rr[e];
                @(posedge clk); #1;
                chk($sformatf("l3 flush edge%0d", e + 1), rdata_l3, exp_l3[e]);
            end
            chk("l3 contents kept", dbg_l3, 32'd15);
            debug_addr = 32'd3; #1;
            chk("l3 mem3", dbg_l3, 32'd33);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
